// File: rtl/cam_probe_arbiter.sv
// Purpose : round-robin share of the cam_bank probe port between NUM_REQ lanes,
//           with results steered back to the issuing lane through an in-order tag FIFO.
// Latency : probe issue is combinational (req -> cam_probe_valid); result -> rsp_valid is 1 cycle.
// Backpres: cam_probe_ready low or MAX_OUTST probes in flight (no pop) stalls all lanes;
//           results have no backpressure.
// Ports   : req_valid/req_key/req_ready   - per-lane probe requests, one-hot accept
//           cam_probe_*                   - probe channel to cam_bank
//           cam_match_*                   - in-order result channel from cam_bank
//           rsp_valid/rsp_hit/id/len      - one-hot result strobe plus shared registered payload
//           outstanding, err_spurious     - in-flight count, sticky result-without-probe flag
module cam_probe_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int KEY_WIDTH = 96,
  parameter int ID_WIDTH  = 32,
  parameter int LEN_WIDTH = 8,
  parameter int MAX_OUTST = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           cam_probe_valid,
  output logic [KEY_WIDTH-1:0]           cam_probe_key,
  input  logic                           cam_probe_ready,
  input  logic                           cam_match_valid,
  input  logic                           cam_match_hit,
  input  logic [ID_WIDTH-1:0]            cam_match_id,
  input  logic [LEN_WIDTH-1:0]           cam_match_len,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_hit,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [LEN_WIDTH-1:0]           rsp_len,
  output logic [$clog2(MAX_OUTST):0]     outstanding,
  output logic                           err_spurious
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int AW   = $clog2(MAX_OUTST);
  localparam int PW   = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(MAX_OUTST);

  // (base + off) mod NUM_REQ; off < NUM_REQ so one conditional subtract suffices.
  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                               input int unsigned     off);
    logic [IDXW:0] s;
    s = {1'b0, base} + (IDXW+1)'(off);
    if (s >= (IDXW+1)'(NUM_REQ)) s = s - (IDXW+1)'(NUM_REQ);
    return s[IDXW-1:0];
  endfunction

  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [IDXW-1:0]      tag_mem_q [MAX_OUTST];
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
  logic [LEN_WIDTH-1:0] rsp_len_q, rsp_len_d;
  logic                 err_q, err_d;

  logic                 grant_found;
  logic [IDXW-1:0]      grant_idx;
  logic [IDXW-1:0]      pop_tag;
  logic [PW-1:0]        occupancy;
  logic                 fifo_empty, fifo_full;
  logic                 pop, push, can_issue;

  // Occupancy is the pointer difference; the extra MSB separates full from empty.
  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (occupancy == FULL_CNT);
  assign pop        = cam_match_valid && !fifo_empty;
  assign pop_tag    = tag_mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot the new tag will occupy, so a full
  // FIFO may still accept.
  assign can_issue       = cam_probe_ready && (!fifo_full || pop);
  assign cam_probe_valid = grant_found && can_issue;
  assign push            = cam_probe_valid && cam_probe_ready;

  // Round-robin search beginning at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[wrap_add(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    cam_probe_key = '0;
    req_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found && grant_idx == IDXW'(i)) begin
        cam_probe_key = req_key[i*KEY_WIDTH +: KEY_WIDTH];
        req_ready[i]  = cam_probe_valid;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = push ? wrap_add(grant_idx, 1) : rr_ptr_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    rsp_valid_d = '0;
    rsp_hit_d   = rsp_hit_q;
    rsp_id_d    = rsp_id_q;
    rsp_len_d   = rsp_len_q;
    if (pop) begin
      rsp_valid_d[pop_tag] = 1'b1;
      rsp_hit_d            = cam_match_hit;
      rsp_id_d             = cam_match_id;
      rsp_len_d            = cam_match_len;
    end
    // A result with nothing in flight is dropped and flagged.
    err_d = err_q || (cam_match_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_id_q    <= rsp_id_d;
      rsp_len_q   <= rsp_len_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q[AW-1:0]] <= grant_idx;
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_hit      = rsp_hit_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_len      = rsp_len_q;
  assign outstanding  = occupancy;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_cam_probe_arbiter.sv
// Purpose : self-checking bench for cam_probe_arbiter against a queue-based reference model.
// Latency : model predicts combinational probe outputs per cycle and registered results 1 cycle later.
// Backpres: bench acts as cam_bank, randomly deasserting cam_probe_ready.
module tb_cam_probe_arbiter;
  localparam int N  = 4;
  localparam int KW = 96;
  localparam int IW = 32;
  localparam int LW = 8;
  localparam int MO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*KW-1:0]   req_key;
  logic [N-1:0]      req_ready;
  logic              cam_probe_valid;
  logic [KW-1:0]     cam_probe_key;
  logic              cam_probe_ready;
  logic              cam_match_valid;
  logic              cam_match_hit;
  logic [IW-1:0]     cam_match_id;
  logic [LW-1:0]     cam_match_len;
  logic [N-1:0]      rsp_valid;
  logic              rsp_hit;
  logic [IW-1:0]     rsp_id;
  logic [LW-1:0]     rsp_len;
  logic [3:0]        outstanding;
  logic              err_spurious;

  logic [KW-1:0]     lane_key [N];

  always_comb begin
    req_key = '0;
    for (int i = 0; i < N; i++) req_key[i*KW +: KW] = lane_key[i];
  end

  cam_probe_arbiter #(
    .NUM_REQ(N), .KEY_WIDTH(KW), .ID_WIDTH(IW), .LEN_WIDTH(LW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .cam_probe_valid(cam_probe_valid), .cam_probe_key(cam_probe_key),
    .cam_probe_ready(cam_probe_ready),
    .cam_match_valid(cam_match_valid), .cam_match_hit(cam_match_hit),
    .cam_match_id(cam_match_id), .cam_match_len(cam_match_len),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_id(rsp_id), .rsp_len(rsp_len),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: in-flight lane tags as a queue, round-robin pointer as an int.
  int            mq[$];
  int            rr;
  logic [N-1:0]  m_rsp_valid;
  logic          m_hit;
  logic [IW-1:0] m_id;
  logic [LW-1:0] m_len;
  logic          m_err;
  // Per-cycle predictions.
  logic          e_pop;
  int            e_g;
  logic          e_any;
  logic          e_pv;
  logic [N-1:0]  e_ready;
  logic [KW-1:0] e_key;

  function automatic logic [KW-1:0] rand_key();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    mq.delete();
    rr          = 0;
    m_rsp_valid = '0;
    m_hit       = 1'b0;
    m_id        = '0;
    m_len       = '0;
    m_err       = 1'b0;
  endtask

  task automatic model_eval();
    logic found;
    found = 1'b0;
    e_g   = 0;
    e_pop = cam_match_valid && (mq.size() > 0);
    e_any = |req_valid;
    for (int k = 0; k < N; k++) begin
      int l;
      l = (rr + k) % N;
      if (!found && req_valid[l]) begin
        found = 1'b1;
        e_g   = l;
      end
    end
    e_pv    = e_any && cam_probe_ready && ((mq.size() < MO) || e_pop);
    e_ready = e_pv ? (N'(1) << e_g) : '0;
    e_key   = e_any ? lane_key[e_g] : '0;
  endtask

  task automatic model_commit();
    int t;
    if (rst) begin
      model_reset();
    end else begin
      m_rsp_valid = '0;
      if (e_pop) begin
        t              = mq.pop_front();
        m_rsp_valid[t] = 1'b1;
        m_hit          = cam_match_hit;
        m_id           = cam_match_id;
        m_len          = cam_match_len;
      end else if (cam_match_valid) begin
        m_err = 1'b1;
      end
      if (e_pv) begin
        mq.push_back(e_g);
        rr = (e_g + 1) % N;
      end
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick_eval();
    model_eval();
    @(negedge clk);
  endtask

  task automatic tick_commit();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    req_valid       = '0;
    cam_probe_ready = 1'b0;
    cam_match_valid = 1'b0;
    cam_match_hit   = 1'b0;
    cam_match_id    = '0;
    cam_match_len   = '0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    req_valid = '0;
    while (mq.size() > 0 && guard < 100) begin
      cam_match_valid = 1'b1;
      cam_match_hit   = 1'($urandom);
      cam_match_id    = $urandom;
      cam_match_len   = 8'($urandom);
      tick_eval();
      tick_commit();
      guard++;
    end
    cam_match_valid = 1'b0;
    tick_eval();
    tick_commit();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick_eval();
    tick_commit();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) begin
      tick_eval();
      tick_commit();
    end
    rst = 1'b0;
    tick_eval();
    checks++;
    if (req_ready !== 4'b0000 || cam_probe_valid !== 1'b0) begin
      errors++; $display("FAIL reset_probe got ready=%b pv=%b exp ready=0000 pv=0", req_ready, cam_probe_valid);
    end
    checks++;
    if (rsp_valid !== 4'b0000 || {rsp_hit, rsp_id, rsp_len} !== 41'd0) begin
      errors++; $display("FAIL reset_rsp got v=%b hit=%b id=%h len=%h exp all 0", rsp_valid, rsp_hit, rsp_id, rsp_len);
    end
    checks++;
    if (outstanding !== 4'd0 || err_spurious !== 1'b0) begin
      errors++; $display("FAIL reset_cnt got outst=%0d err=%b exp 0/0", outstanding, err_spurious);
    end
    tick_commit();
  endtask

  task automatic test_single_lane();
    logic [KW-1:0] k;
    logic          hits [3] = '{1'b1, 1'b0, 1'b1};
    logic [IW-1:0] ids  [3] = '{32'd5, 32'd0, 32'd9};
    logic [LW-1:0] lens [3] = '{8'd4, 8'd0, 8'd12};
    cam_probe_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      k            = rand_key();
      lane_key[0]  = k;
      req_valid    = 4'b0001;
      tick_eval();
      checks++;
      if (req_ready !== 4'b0001 || cam_probe_valid !== 1'b1 || cam_probe_key !== k) begin
        errors++; $display("FAIL single_issue%0d got ready=%b pv=%b key=%h exp 0001/1/%h", j, req_ready, cam_probe_valid, cam_probe_key, k);
      end
      tick_commit();
    end
    req_valid = '0;
    tick_eval();
    checks++;
    if (outstanding !== 4'd3) begin
      errors++; $display("FAIL single_outst got %0d exp 3", outstanding);
    end
    tick_commit();
    for (int j = 0; j < 3; j++) begin
      cam_match_valid = 1'b1;
      cam_match_hit   = hits[j];
      cam_match_id    = ids[j];
      cam_match_len   = lens[j];
      tick_eval();
      checks++;
      if (rsp_valid !== 4'b0000) begin
        errors++; $display("FAIL single_early%0d got rsp_valid=%b exp 0000", j, rsp_valid);
      end
      tick_commit();
      cam_match_valid = 1'b0;
      cam_match_hit   = 1'b0;
      cam_match_id    = 32'hdead_beef;
      cam_match_len   = 8'hff;
      tick_eval();
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_hit !== hits[j] || rsp_id !== ids[j] || rsp_len !== lens[j]) begin
        errors++; $display("FAIL single_rsp%0d got v=%b hit=%b id=%0d len=%0d exp 0001/%b/%0d/%0d", j, rsp_valid, rsp_hit, rsp_id, rsp_len, hits[j], ids[j], lens[j]);
      end
      tick_commit();
    end
    tick_eval();
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_id !== 32'd9 || outstanding !== 4'd0) begin
      errors++; $display("FAIL single_hold got v=%b id=%0d outst=%0d exp 0000/9/0", rsp_valid, rsp_id, outstanding);
    end
    tick_commit();
  endtask

  task automatic test_fairness();
    int cnt [N];
    int accepted;
    int cyc;
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      cnt[i]      = 0;
      lane_key[i] = rand_key();
    end
    accepted        = 0;
    cyc             = 0;
    req_valid       = '1;
    cam_probe_ready = 1'b1;
    while (accepted < 400 && cyc < 2000) begin
      cam_match_valid = (mq.size() > 0);
      cam_match_hit   = 1'($urandom);
      cam_match_id    = $urandom;
      cam_match_len   = 8'($urandom);
      tick_eval();
      checks++;
      if (req_ready !== e_ready || cam_probe_valid !== e_pv) begin
        errors++; $display("FAIL fair_grant cyc%0d got ready=%b pv=%b exp %b/%b", cyc, req_ready, cam_probe_valid, e_ready, e_pv);
      end
      acc = req_ready;
      for (int i = 0; i < N; i++) if (acc[i]) begin cnt[i]++; accepted++; end
      tick_commit();
      for (int i = 0; i < N; i++) if (acc[i]) lane_key[i] = rand_key();
      cyc++;
    end
    checks++;
    if (accepted < 400) begin
      errors++; $display("FAIL fair_budget got %0d accepts exp 400", accepted);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (cnt[i] < 99 || cnt[i] > 101) begin
        errors++; $display("FAIL fair_share lane%0d got %0d exp 100+/-1", i, cnt[i]);
      end
    end
    drain();
  endtask

  task automatic test_full();
    logic [N-1:0] acc;
    req_valid       = '1;
    cam_probe_ready = 1'b1;
    cam_match_valid = 1'b0;
    for (int j = 0; j < MO; j++) begin
      tick_eval();
      checks++;
      if (req_ready !== e_ready || cam_probe_valid !== 1'b1) begin
        errors++; $display("FAIL full_fill%0d got ready=%b pv=%b exp %b/1", j, req_ready, cam_probe_valid, e_ready);
      end
      acc = req_ready;
      tick_commit();
      for (int i = 0; i < N; i++) if (acc[i]) lane_key[i] = rand_key();
    end
    tick_eval();
    checks++;
    if (outstanding !== 4'd8 || req_ready !== 4'b0000 || cam_probe_valid !== 1'b0) begin
      errors++; $display("FAIL full_stall got outst=%0d ready=%b pv=%b exp 8/0000/0", outstanding, req_ready, cam_probe_valid);
    end
    tick_commit();
    cam_match_valid = 1'b1;
    cam_match_hit   = 1'b1;
    cam_match_id    = 32'd77;
    cam_match_len   = 8'd3;
    tick_eval();
    checks++;
    if (cam_probe_valid !== 1'b1 || req_ready !== e_ready) begin
      errors++; $display("FAIL full_popissue got pv=%b ready=%b exp 1/%b", cam_probe_valid, req_ready, e_ready);
    end
    tick_commit();
    cam_match_valid = 1'b0;
    req_valid       = '0;
    tick_eval();
    checks++;
    if (outstanding !== 4'd8 || rsp_valid !== m_rsp_valid || rsp_id !== 32'd77) begin
      errors++; $display("FAIL full_hold got outst=%0d v=%b id=%0d exp 8/%b/77", outstanding, rsp_valid, rsp_id, m_rsp_valid);
    end
    tick_commit();
    drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    lane_key[1]     = rand_key();
    lane_key[3]     = rand_key();
    req_valid       = 4'b1010;
    cam_probe_ready = 1'b0;
    repeat (3) begin
      tick_eval();
      checks++;
      if (req_ready !== 4'b0000 || cam_probe_valid !== 1'b0) begin
        errors++; $display("FAIL bp_stall got ready=%b pv=%b exp 0000/0", req_ready, cam_probe_valid);
      end
      tick_commit();
    end
    cam_probe_ready = 1'b1;
    tick_eval();
    checks++;
    if (req_ready !== 4'b0010 || cam_probe_key !== lane_key[1]) begin
      errors++; $display("FAIL bp_first got ready=%b key=%h exp 0010/%h", req_ready, cam_probe_key, lane_key[1]);
    end
    tick_commit();
    req_valid = 4'b1000;
    tick_eval();
    checks++;
    if (req_ready !== 4'b1000 || cam_probe_key !== lane_key[3]) begin
      errors++; $display("FAIL bp_second got ready=%b key=%h exp 1000/%h", req_ready, cam_probe_key, lane_key[3]);
    end
    tick_commit();
    drain();
  endtask

  task automatic test_spurious();
    idle_inputs();
    cam_match_valid = 1'b1;
    cam_match_hit   = 1'b1;
    cam_match_id    = 32'h1234_5678;
    cam_match_len   = 8'd55;
    tick_eval();
    checks++;
    if (outstanding !== 4'd0 || err_spurious !== 1'b0) begin
      errors++; $display("FAIL spur_pre got outst=%0d err=%b exp 0/0", outstanding, err_spurious);
    end
    tick_commit();
    cam_match_valid = 1'b0;
    tick_eval();
    checks++;
    if (rsp_valid !== 4'b0000 || err_spurious !== 1'b1 || rsp_id === 32'h1234_5678) begin
      errors++; $display("FAIL spur_flag got v=%b err=%b id=%h exp 0000/1/held", rsp_valid, err_spurious, rsp_id);
    end
    tick_commit();
    repeat (4) begin tick_eval(); tick_commit(); end
    tick_eval();
    checks++;
    if (err_spurious !== 1'b1) begin
      errors++; $display("FAIL spur_sticky got err=%b exp 1", err_spurious);
    end
    tick_commit();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < N; i++) lane_key[i] = rand_key();
    req_valid       = '1;
    cam_probe_ready = 1'b1;
    repeat (5) begin tick_eval(); tick_commit(); end
    req_valid = '0;
    tick_eval();
    checks++;
    if (outstanding !== 4'd5) begin
      errors++; $display("FAIL mid_pre got outst=%0d exp 5", outstanding);
    end
    tick_commit();
    cam_match_valid = 1'b1;
    rst             = 1'b1;
    tick_eval();
    tick_commit();
    rst             = 1'b0;
    cam_match_valid = 1'b0;
    req_valid       = '1;
    tick_eval();
    checks++;
    if (outstanding !== 4'd0 || rsp_valid !== 4'b0000 || err_spurious !== 1'b0) begin
      errors++; $display("FAIL mid_clear got outst=%0d v=%b err=%b exp 0/0000/0", outstanding, rsp_valid, err_spurious);
    end
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_rrptr got ready=%b exp 0001", req_ready);
    end
    tick_commit();
    drain();
  endtask

  task automatic test_random();
    logic [N-1:0] prev_ready;
    prev_ready = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || prev_ready[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          lane_key[i]  = rand_key();
        end else if ($urandom_range(0, 99) < 3) begin
          req_valid[i] = 1'b0;
        end
      end
      cam_probe_ready = ($urandom_range(0, 99) < 75);
      cam_match_valid = (mq.size() > 0) && ($urandom_range(0, 99) < 45);
      cam_match_hit   = 1'($urandom);
      cam_match_id    = $urandom;
      cam_match_len   = 8'($urandom);
      tick_eval();
      checks++;
      if (req_ready !== e_ready || cam_probe_valid !== e_pv) begin
        errors++; $display("FAIL rnd_grant c%0d got ready=%b pv=%b exp %b/%b", c, req_ready, cam_probe_valid, e_ready, e_pv);
      end
      checks++;
      if (e_pv && cam_probe_key !== e_key) begin
        errors++; $display("FAIL rnd_key c%0d got %h exp %h", c, cam_probe_key, e_key);
      end
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_hit !== m_hit || rsp_id !== m_id || rsp_len !== m_len) begin
        errors++; $display("FAIL rnd_rsp c%0d got %b/%b/%h/%h exp %b/%b/%h/%h", c, rsp_valid, rsp_hit, rsp_id, rsp_len, m_rsp_valid, m_hit, m_id, m_len);
      end
      checks++;
      if (outstanding !== 4'(mq.size()) || err_spurious !== m_err) begin
        errors++; $display("FAIL rnd_cnt c%0d got outst=%0d err=%b exp %0d/%b", c, outstanding, err_spurious, mq.size(), m_err);
      end
      prev_ready = e_ready;
      tick_commit();
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < N; i++) lane_key[i] = '0;
    model_reset();
    #1;
    test_reset();
    test_single_lane();
    test_fairness();
    test_full();
    test_random();
    test_backpressure();
    test_spurious();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
